div_iter_unit: RTL
==================

Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU, placed in the execute stage beside the ALU.
- Produces the div_stall request that the hazard unit folds into its longest-stall term.
- Consumes the hazard unit's flush and pipeline-hold outputs.
- Writes quotient to LO and remainder to HI.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- startE  in  1  DIV/DIVU instruction valid in execute stage.
- signedE  in  1  1 = DIV (signed), 0 = DIVU.
- a  in  WIDTH  dividend (rs, post-forwarding).
- b  in  WIDTH  divisor (rt, post-forwarding).
- flush  in  1  exception flush (is_exceptM); aborts any operation.
- hold  in  1  execute stage held by a non-divider stall (instr/data/mul).
- div_stall  out  1  request to stall F..W.
- result_valid  out  1  hi_out/lo_out valid for the instruction in E.
- hi_out  out  WIDTH  remainder.
- lo_out  out  WIDTH  quotient.

Behaviour:
- States: IDLE, BUSY, DONE (2-bit encoding).
- Reset (resetn low, async): state=IDLE, counter=0, all outputs 0.
- IDLE:
  - If startE & ~flush: latch |a|, |b| (absolute values only when signedE), sign of quotient (a[31]^b[31])&signedE, sign of remainder a[31]&signedE; counter=0; go BUSY.
- BUSY:
  - One restoring iteration per cycle: shift partial remainder left 1 and bring in the next dividend bit; subtract divisor; if non-negative, keep the difference and set the quotient bit, else restore.
  - At counter==WIDTH-1, go DONE; otherwise counter++.
- DONE:
  - result_valid=1.
  - hi_out/lo_out hold the sign-corrected results: quotient negated if the quotient-sign flag is set, remainder negated if the remainder-sign flag is set.
  - Stay in DONE while hold=1.
  - When hold=0, go IDLE next cycle. startE is ignored in DONE because the same instruction is still in E.
- div_stall (combinational) = ((state==IDLE & startE) | state==BUSY) & ~flush. Low in DONE.
- Latency: start in cycle 0 gives div_stall high in cycles 0..32 and DONE/result_valid in cycle 33. That is 33 stall cycles for WIDTH=32.
- flush in any state: next state IDLE; div_stall forced low in the same cycle; result_valid drops next edge; no partial result is exposed.
- hold asserted during BUSY: no effect; iterations continue.
- Divide by zero: still 32 iterations, no early exit. lo_out=all ones, hi_out=a, regardless of signedE.
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed): lo_out=0x80000000, hi_out=0. The natural result of the abs/negate path must yield this.
- hi_out/lo_out hold their value after DONE until the next completion or reset.
- resetn asserted mid-BUSY returns to IDLE immediately.

Decomposition:
- Shared package (cpu_defs): state encodings DIV_IDLE/DIV_BUSY/DIV_DONE, WIDTH default.
- Optional sub-module div_sign_fix (combinational abs and negate helper), used at the input and output.
- The iteration datapath stays inline.

Test Plan:
- DIVU a=100, b=7, startE held until result_valid: div_stall high for exactly 33 cycles; cycle 33 gives lo=14, hi=2, div_stall=0.
- DIV a=-7 (0xFFFFFFF9), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with a=7, b=-2: lo=-3, hi=1.
- DIVU a=5, b=0: after 33 cycles lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- Flush asserted at BUSY iteration 10: div_stall low in the same cycle, state IDLE next cycle, result_valid never asserted. A new DIVU 9/3 started next gives lo=3, hi=0 after 33 cycles.
- hold=1 for 4 cycles beginning at DONE: result_valid stays 1 for 5 cycles with stable outputs and no restart despite startE=1; IDLE follows.
- Async reset pulse mid-BUSY: all outputs 0 immediately; div_stall=0 while startE=0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the execute-stage divider: FSM state encodings and default width.
package cpu_defs;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; serves as |x| on the way in and sign restore on the way out.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  assign res = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/div_iter_unit.sv
// Radix-2 restoring DIV/DIVU unit: one quotient bit per cycle, quotient to LO, remainder to HI.
module div_iter_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hold,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             q_neg, r_neg;

  logic [WIDTH-1:0] a_abs, b_abs, quo_fix, rem_fix;
  logic [WIDTH:0]   rem_shift, diff;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic             start_ok;

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.val(a), .neg(signedE & a[WIDTH-1]), .res(a_abs));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.val(b), .neg(signedE & b[WIDTH-1]), .res(b_abs));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.val(quo_next), .neg(q_neg), .res(quo_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.val(rem_next), .neg(r_neg), .res(rem_fix));

  assign start_ok = (state == DIV_IDLE) & startE & ~flush;

  // The dividend register doubles as the quotient: dividend bits shift out the top as quotient bits enter the bottom.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs};
  assign rem_next  = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], ~diff[WIDTH]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    div_stall    = 1'b0;
    result_valid = 1'b0;
    case (state)
      DIV_IDLE: begin
        div_stall = startE;
        if (startE) state_next = DIV_BUSY;
      end
      DIV_BUSY: begin
        div_stall = 1'b1;
        if (counter == LAST) state_next = DIV_DONE;
      end
      DIV_DONE: begin
        result_valid = 1'b1;
        if (!hold) state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase
    if (flush) begin
      state_next = DIV_IDLE;
      div_stall  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else if (start_ok) begin
      counter <= '0;
      rem     <= '0;
      quo     <= a_abs;
      dvs     <= b_abs;
      // A zero divisor must give an all-ones quotient for signed ops too, so never negate it.
      q_neg   <= (a[WIDTH-1] ^ b[WIDTH-1]) & signedE & (b != '0);
      r_neg   <= a[WIDTH-1] & signedE;
    end else if (state == DIV_BUSY && !flush) begin
      rem <= rem_next;
      quo <= quo_next;
      if (counter == LAST) begin
        hi_out <= rem_fix;
        lo_out <= quo_fix;
      end else begin
        counter <= counter + CNT_W'(1);
      end
    end
  end

endmodule
